// File: rtl/fir_feed_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared defaults and FSM state encoding for the FIR feed block.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int c_wl    = 8;
    localparam int c_ntaps = 3;
    localparam int c_depth = 4;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_load  = 2'd1;
    localparam state_t c_st_run   = 2'd2;
    localparam state_t c_st_flush = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fir_feed_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sample_fifo
// Description : Show-ahead sample FIFO with occupancy count, async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_fifo
    import fir_pkg::*;
#(
    parameter int W     = c_wl + 1,
    parameter int DEPTH = c_depth
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int            c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_count = (c_aw + 1)'(DEPTH);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == c_full_count);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    // Storage carries no reset; only entries below r_count are ever read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_feed_ctrl
// Description : Loads FIR coefficients, then streams buffered samples and
//               flushes the filter, pulsing done at the end of each frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_feed_ctrl
    import fir_pkg::*;
#(
    parameter int WL    = c_wl,
    parameter int NTAPS = c_ntaps,
    parameter int DEPTH = c_depth
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [WL-1:0] coef_in,
    input  logic          coef_valid,
    output logic          coef_ready,
    input  logic [WL-1:0] smp_in,
    input  logic          smp_valid,
    output logic          smp_ready,
    input  logic          smp_last,
    output logic [WL-1:0] x,
    output logic [WL-1:0] h,
    output logic          x_en,
    output logic          busy,
    output logic          done
);

    localparam int                 c_cnt_w    = $clog2(NTAPS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(NTAPS - 1);
    localparam int                 c_cw       = $clog2(DEPTH) + 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_last_seen;
    logic [WL-1:0]      r_x;
    logic [WL-1:0]      w_x_nxt;
    logic [WL-1:0]      r_h;
    logic [WL-1:0]      w_h_nxt;
    logic               r_x_en;
    logic               w_x_en_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_push;
    logic               w_pop;
    logic               w_coef_hs;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [c_cw-1:0]    w_fifo_count;
    logic [WL:0]        w_fifo_dout;

    // The FIFO word carries the last-sample flag above the sample data.
    sample_fifo #(
        .W     (WL + 1),
        .DEPTH (DEPTH)
    ) u_sample_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({smp_last, smp_in}),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign coef_ready = (r_state == c_st_load);
    assign smp_ready  = ((r_state == c_st_load) || (r_state == c_st_run))
                        && !w_fifo_full && !r_last_seen;
    assign busy       = (r_state != c_st_idle);
    assign w_coef_hs  = coef_valid && coef_ready;
    assign w_push     = smp_valid && smp_ready;
    assign w_pop      = (r_state == c_st_run) && !w_fifo_empty && (w_fifo_count != '0);

    assign x    = r_x;
    assign h    = r_h;
    assign x_en = r_x_en;
    assign done = r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_x_nxt     = '0;
        w_h_nxt     = r_h;
        w_x_en_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_load;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_load: begin
                if (w_coef_hs) begin
                    w_h_nxt    = coef_in;
                    w_x_en_nxt = 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = c_st_run;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_w'(1);
                    end
                end
            end
            c_st_run: begin
                if (w_pop) begin
                    w_x_nxt = w_fifo_dout[WL-1:0];
                    if (w_fifo_dout[WL]) begin
                        w_state_nxt = c_st_flush;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            c_st_flush: begin
                // Registered outputs lag by a cycle, so NTAPS flush cycles
                // yield NTAPS-1 zero samples on x ahead of the done pulse.
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_last_seen <= 1'b0;
            r_x         <= '0;
            r_h         <= '0;
            r_x_en      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_x     <= w_x_nxt;
            r_h     <= w_h_nxt;
            r_x_en  <= w_x_en_nxt;
            r_done  <= w_done_nxt;
            if ((r_state != c_st_idle) && (w_state_nxt == c_st_idle)) begin
                r_last_seen <= 1'b0;
            end else if (w_push && smp_last) begin
                r_last_seen <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
